batch_seq_controller: RTL and testbench

- Parametrised successor to the single-pass file/compute sequencer. Drives file read, register load, calculation and file write for a batch of items, one item at a time.
- Batch length is set at run time and latched on `start`. Adds a calculation timeout with error reporting, an abort input and a `busy` status.
- Sits between the top-level testbench/file-I/O harness and the compute datapath.

---
 rtl/batch_seq_controller.sv | 101 ++++++++++
 tb/tb_batch_seq_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_seq_controller.sv
// Batch sequencer: walks items 0..cfg_last through read -> load -> calculate -> write,
// with a bounded wait on the datapath, abort, and busy/error status.
module batch_seq_controller #(
  parameter int IDX_W       = 8,
  parameter int CAL_TIMEOUT = 1024,
  parameter int TMO_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] cfg_last,
  input  logic             finish_read,
  input  logic             cal_finish,
  output logic             dp_clr,
  output logic             read_file,
  output logic             write_reg,
  output logic             write_file,
  output logic [IDX_W-1:0] index,
  output logic             finish,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE, INIT, READ, REG_WRITE, CAL, WRITE, DONE, ERR
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CAL_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] last_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // A zero timeout leaves the counter free-running but never acted upon.
  assign tmo_hit = (CAL_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign busy    = !(state inside {IDLE, DONE, ERR});

  always_comb begin
    state_nxt  = state;
    dp_clr     = 1'b0;
    read_file  = 1'b0;
    write_reg  = 1'b0;
    write_file = 1'b0;
    finish     = 1'b0;
    error      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = INIT;
      INIT: begin
        dp_clr    = 1'b1;
        read_file = 1'b1;
        state_nxt = READ;
      end
      READ: if (finish_read) state_nxt = REG_WRITE;
      REG_WRITE: begin
        write_reg = 1'b1;
        state_nxt = CAL;
      end
      CAL: begin
        if (cal_finish)   state_nxt = WRITE;
        else if (tmo_hit) state_nxt = ERR;
      end
      WRITE: begin
        write_file = 1'b1;
        state_nxt  = (index == last_q) ? DONE : REG_WRITE;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = start ? INIT : IDLE;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nxt = INIT;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort only cancels active work; pulses of this cycle above still fire.
    if (busy && abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      index   <= '0;
      last_q  <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start && !busy) last_q <= cfg_last;
      unique case (state)
        INIT:      index   <= '0;
        REG_WRITE: tmo_cnt <= '0;
        CAL:       tmo_cnt <= tmo_cnt + TMO_W'(1);
        WRITE:     if (index != last_q) index <= index + IDX_W'(1);
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_batch_seq_controller.sv
// Randomised bench: expected event timelines are computed from per-item latency arithmetic.
module tb_batch_seq_controller;
  localparam int IDX_W = 4, CAL_TIMEOUT = 8, TMO_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, abort, finish_read, cal_finish;
  logic [IDX_W-1:0] cfg_last, index;
  logic             dp_clr, read_file, write_reg, write_file, finish, busy, error;

  // kind: 0 INIT (idx = {dp_clr,read_file}), 1 write_reg, 2 write_file, 3 finish, 4 error
  typedef struct packed { logic [31:0] cyc; logic [31:0] kind; logic [31:0] idx; } ev_t;
  ev_t        obs_ev[$], exp_ev[$];
  logic [1:0] obs_st[$], exp_st[$];   // {busy,error} per cycle from s+1
  int         cal_dly[16];
  int         cyc = 0, checks = 0, errors = 0, model_end = 0;
  bit         budget_hit;

  batch_seq_controller #(.IDX_W(IDX_W), .CAL_TIMEOUT(CAL_TIMEOUT), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_last(cfg_last),
    .finish_read(finish_read), .cal_finish(cal_finish), .dp_clr(dp_clr),
    .read_file(read_file), .write_reg(write_reg), .write_file(write_file),
    .index(index), .finish(finish), .busy(busy), .error(error));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int c, input int k, input int i);
    ev_t e;
    e.cyc = 32'(c); e.kind = 32'(k); e.idx = 32'(i);
    return e;
  endfunction

  // Called at a negedge with the DUT in IDLE/DONE/ERR; start is sampled in cycle s.
  task automatic drive_batch(input int last, input int rd, input int abort_rel,
                             input int noise_rel, input bit hold_start);
    int s, rf, wr, widx, n;
    bit done;
    obs_ev.delete(); obs_st.delete();
    s = cyc; rf = -1000; wr = -1000; widx = 0; budget_hit = 0; done = 0;
    start = 1; cfg_last = IDX_W'(last); abort = 0; finish_read = 0; cal_finish = 0;
    while (!done) begin
      @(negedge clk);
      n = cyc;
      if (dp_clr || read_file) begin obs_ev.push_back(mk_ev(n, 0, {dp_clr, read_file})); rf = n; end
      if (write_reg) begin obs_ev.push_back(mk_ev(n, 1, index)); wr = n; widx = index; end
      if (write_file) obs_ev.push_back(mk_ev(n, 2, index));
      if (finish)     obs_ev.push_back(mk_ev(n, 3, index));
      if (error)      obs_ev.push_back(mk_ev(n, 4, index));
      obs_st.push_back({busy, error});
      start       = (n - s == noise_rel);
      abort       = (n - s == abort_rel);
      finish_read = (n == rf + rd);
      cal_finish  = (n == wr + cal_dly[widx]);
      if (finish || error || (abort_rel >= 0 && n - s > abort_rel) || n - s > 3000) begin
        done = 1;
        budget_hit = (n - s > 3000);
        start = hold_start; abort = 0; finish_read = 0; cal_finish = 0;
      end
    end
  endtask

  // Item i: load at w, result written at w+d+1, next load at w+d+2; wait beyond
  // CAL_TIMEOUT calculation cycles ends the batch in error at w+CAL_TIMEOUT+1.
  task automatic model_batch(input int s, input int last, input int rd, input int abort_rel);
    int w, endc;
    bit err;
    exp_ev.delete(); exp_st.delete();
    exp_ev.push_back(mk_ev(s + 1, 0, 3));
    w = s + rd + 2; err = 0; endc = 0;
    for (int i = 0; i <= last; i++) begin
      exp_ev.push_back(mk_ev(w, 1, i));
      if (cal_dly[i] > CAL_TIMEOUT) begin
        endc = w + CAL_TIMEOUT + 1;
        exp_ev.push_back(mk_ev(endc, 4, i));
        err = 1;
        break;
      end
      exp_ev.push_back(mk_ev(w + cal_dly[i] + 1, 2, i));
      if (i == last) begin
        endc = w + cal_dly[i] + 2;
        exp_ev.push_back(mk_ev(endc, 3, i));
      end
      w += cal_dly[i] + 2;
    end
    if (abort_rel >= 0) begin
      endc = s + abort_rel + 1; err = 0;
      while (exp_ev.size() > 0 && int'(exp_ev[$].cyc) > s + abort_rel) void'(exp_ev.pop_back());
    end
    for (int n = s + 1; n <= endc; n++) exp_st.push_back({n < endc, err && n == endc});
    model_end = endc;
  endtask

  task automatic test_reset;
    rst = 1; start = 0; abort = 0; finish_read = 0; cal_finish = 0; cfg_last = '0;
    repeat (3) @(negedge clk);
    checks++; if ({dp_clr, read_file, write_reg, write_file} !== 4'b0) begin errors++;
      $display("FAIL reset_pulses got %b exp 0000", {dp_clr, read_file, write_reg, write_file}); end
    checks++; if ({finish, busy, error} !== 3'b0) begin errors++;
      $display("FAIL reset_status got %b exp 000", {finish, busy, error}); end
    checks++; if (index !== '0) begin errors++; $display("FAIL reset_index got %0d exp 0", index); end
    rst = 0;
    @(negedge clk);
    checks++; if ({busy, dp_clr} !== 2'b0) begin errors++;
      $display("FAIL idle_hold got %b exp 00", {busy, dp_clr}); end
  endtask

  task automatic test_basic;
    int s;
    for (int i = 0; i < 16; i++) cal_dly[i] = 2;
    s = cyc;
    drive_batch(3, 5, -1, -1, 0);
    model_batch(s, 3, 5, -1);
    checks++; if (budget_hit) begin errors++; $display("FAIL basic budget got 1 exp 0"); end
    checks++; if (obs_ev.size() != exp_ev.size()) begin errors++;
      $display("FAIL basic ev_count got %0d exp %0d", obs_ev.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++;
        $display("FAIL basic ev%0d got c%0d k%0d i%0d exp c%0d k%0d i%0d", i, obs_ev[i].cyc, obs_ev[i].kind,
                 obs_ev[i].idx, exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].idx); end
    end
    for (int i = 0; i < exp_st.size() && i < obs_st.size(); i++) begin
      checks++; if (obs_st[i] !== exp_st[i]) begin errors++;
        $display("FAIL basic busy_err cycle %0d got %b exp %b", s + 1 + i, obs_st[i], exp_st[i]); end
    end
  endtask

  task automatic test_single;
    int s;
    for (int i = 0; i < 16; i++) cal_dly[i] = 1;
    @(negedge clk);
    s = cyc;
    drive_batch(0, 1, -1, -1, 0);
    model_batch(s, 0, 1, -1);
    checks++; if (obs_ev.size() != exp_ev.size()) begin errors++;
      $display("FAIL single ev_count got %0d exp %0d", obs_ev.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++;
        $display("FAIL single ev%0d got c%0d k%0d i%0d exp c%0d k%0d i%0d", i, obs_ev[i].cyc, obs_ev[i].kind,
                 obs_ev[i].idx, exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].idx); end
    end
    checks++; if (obs_ev.size() == 0 || int'(obs_ev[$].cyc) - s != 6 || obs_ev[$].kind != 3) begin errors++;
      $display("FAIL single finish_latency got %0d exp 6", obs_ev.size() ? int'(obs_ev[$].cyc) - s : -1); end
  endtask

  task automatic test_timeout;
    int s;
    for (int i = 0; i < 16; i++) cal_dly[i] = 1;
    cal_dly[1] = 100;
    @(negedge clk);
    s = cyc;
    drive_batch(2, 2, -1, -1, 0);
    model_batch(s, 2, 2, -1);
    checks++; if (obs_ev.size() != exp_ev.size()) begin errors++;
      $display("FAIL timeout ev_count got %0d exp %0d", obs_ev.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++;
        $display("FAIL timeout ev%0d got c%0d k%0d i%0d exp c%0d k%0d i%0d", i, obs_ev[i].cyc, obs_ev[i].kind,
                 obs_ev[i].idx, exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].idx); end
    end
    for (int i = 0; i < exp_st.size() && i < obs_st.size(); i++) begin
      checks++; if (obs_st[i] !== exp_st[i]) begin errors++;
        $display("FAIL timeout busy_err cycle %0d got %b exp %b", s + 1 + i, obs_st[i], exp_st[i]); end
    end
    repeat (3) @(negedge clk);
    checks++; if ({error, busy, finish, index} !== {3'b100, 4'd1}) begin errors++;
      $display("FAIL err_hold got e%b b%b f%b i%0d exp e1 b0 f0 i1", error, busy, finish, index); end
    // Restart straight out of ERR.
    for (int i = 0; i < 16; i++) cal_dly[i] = 1;
    s = cyc;
    drive_batch(1, 1, -1, -1, 0);
    model_batch(s, 1, 1, -1);
    checks++; if (obs_ev.size() != exp_ev.size()) begin errors++;
      $display("FAIL err_restart ev_count got %0d exp %0d", obs_ev.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++;
        $display("FAIL err_restart ev%0d got c%0d k%0d i%0d exp c%0d k%0d i%0d", i, obs_ev[i].cyc, obs_ev[i].kind,
                 obs_ev[i].idx, exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].idx); end
    end
  endtask

  task automatic test_timeout_edge;
    int s;
    for (int i = 0; i < 16; i++) cal_dly[i] = CAL_TIMEOUT;
    @(negedge clk);
    s = cyc;
    drive_batch(1, 3, -1, -1, 0);
    model_batch(s, 1, 3, -1);
    checks++; if (obs_ev.size() != exp_ev.size()) begin errors++;
      $display("FAIL tmo_edge ev_count got %0d exp %0d", obs_ev.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++;
        $display("FAIL tmo_edge ev%0d got c%0d k%0d i%0d exp c%0d k%0d i%0d", i, obs_ev[i].cyc, obs_ev[i].kind,
                 obs_ev[i].idx, exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].idx); end
    end
  endtask

  task automatic test_abort;
    int s;
    for (int i = 0; i < 16; i++) cal_dly[i] = 2;
    @(negedge clk);
    s = cyc;
    // Loads at s+5, s+9, s+13; item 2 calculates in s+14..s+15.
    drive_batch(5, 3, 14, 4, 0);
    model_batch(s, 5, 3, 14);
    checks++; if (obs_ev.size() != exp_ev.size()) begin errors++;
      $display("FAIL abort ev_count got %0d exp %0d", obs_ev.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++;
        $display("FAIL abort ev%0d got c%0d k%0d i%0d exp c%0d k%0d i%0d", i, obs_ev[i].cyc, obs_ev[i].kind,
                 obs_ev[i].idx, exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].idx); end
    end
    for (int i = 0; i < exp_st.size() && i < obs_st.size(); i++) begin
      checks++; if (obs_st[i] !== exp_st[i]) begin errors++;
        $display("FAIL abort busy_err cycle %0d got %b exp %b", s + 1 + i, obs_st[i], exp_st[i]); end
    end
    cal_finish = 1;
    repeat (4) begin
      @(negedge clk);
      checks++; if ({busy, write_file, finish, error} !== 4'b0) begin errors++;
        $display("FAIL abort_idle got %b exp 0000", {busy, write_file, finish, error}); end
    end
    cal_finish = 0;
  endtask

  task automatic test_back_to_back;
    int s, last2, k;
    for (int i = 0; i < 16; i++) cal_dly[i] = $urandom_range(CAL_TIMEOUT, 1);
    s = cyc;
    drive_batch(15, 2, -1, -1, 1);
    model_batch(s, 15, 2, -1);
    checks++; if (obs_ev.size() != exp_ev.size()) begin errors++;
      $display("FAIL b2b_full ev_count got %0d exp %0d", obs_ev.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++;
        $display("FAIL b2b_full ev%0d got c%0d k%0d i%0d exp c%0d k%0d i%0d", i, obs_ev[i].cyc, obs_ev[i].kind,
                 obs_ev[i].idx, exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].idx); end
    end
    // Start was held through DONE, so the next batch's start cycle is the DONE cycle.
    last2 = $urandom_range(15, 0);
    s = cyc;
    drive_batch(last2, 1, -1, -1, 0);
    model_batch(s, last2, 1, -1);
    checks++; if (obs_ev.size() != exp_ev.size()) begin errors++;
      $display("FAIL b2b_next ev_count got %0d exp %0d", obs_ev.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++;
        $display("FAIL b2b_next ev%0d got c%0d k%0d i%0d exp c%0d k%0d i%0d", i, obs_ev[i].cyc, obs_ev[i].kind,
                 obs_ev[i].idx, exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].idx); end
    end
    // Reset in the middle of a calculation, with abort and start also asserted.
    @(negedge clk);
    start = 1; cfg_last = 4'd3; finish_read = 1; k = 0;
    @(negedge clk);
    start = 0;
    while (!write_reg && k < 50) begin @(negedge clk); k++; end
    checks++; if (write_reg !== 1'b1) begin errors++; $display("FAIL rst_mid_cal wait_write_reg got 0 exp 1"); end
    @(negedge clk);
    rst = 1; abort = 1; start = 1;
    @(negedge clk);
    checks++; if ({dp_clr, read_file, write_reg, write_file, finish, busy, error} !== 7'b0) begin errors++;
      $display("FAIL rst_mid_cal outs got %b exp 0000000",
               {dp_clr, read_file, write_reg, write_file, finish, busy, error}); end
    checks++; if (index !== '0) begin errors++; $display("FAIL rst_mid_cal index got %0d exp 0", index); end
    rst = 0; abort = 0; start = 0; finish_read = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release busy got %b exp 0", busy); end
  endtask

  task automatic test_random;
    int s, last, rd, ab, nz;
    for (int it = 0; it < 20; it++) begin
      last = $urandom_range(15, 0);
      rd   = $urandom_range(6, 1);
      for (int i = 0; i < 16; i++)
        cal_dly[i] = ($urandom_range(9, 0) == 0) ? CAL_TIMEOUT + 1 + $urandom_range(3, 0)
                                                 : $urandom_range(CAL_TIMEOUT, 1);
      nz = ($urandom_range(1, 0) != 0) ? $urandom_range(6, 2) : -1;
      s = cyc;
      model_batch(s, last, rd, -1);
      ab = ($urandom_range(3, 0) == 0) ? $urandom_range(model_end - s - 1, 1) : -1;
      model_batch(s, last, rd, ab);
      drive_batch(last, rd, ab, nz, 0);
      checks++; if (obs_ev.size() != exp_ev.size()) begin errors++;
        $display("FAIL random%0d ev_count got %0d exp %0d", it, obs_ev.size(), exp_ev.size()); end
      for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
        checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++;
          $display("FAIL random%0d ev%0d got c%0d k%0d i%0d exp c%0d k%0d i%0d", it, i, obs_ev[i].cyc,
                   obs_ev[i].kind, obs_ev[i].idx, exp_ev[i].cyc, exp_ev[i].kind, exp_ev[i].idx); end
      end
      for (int i = 0; i < exp_st.size() && i < obs_st.size(); i++) begin
        checks++; if (obs_st[i] !== exp_st[i]) begin errors++;
          $display("FAIL random%0d busy_err cycle %0d got %b exp %b", it, s + 1 + i, obs_st[i], exp_st[i]); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_single;
    test_timeout;
    test_timeout_edge;
    test_abort;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
